// File: rtl/stft_frame_buffer.sv
// Circular sample buffer emitting overlapping STFT analysis frames.
// Ports: cfg_* window/hop config, s_* sample in, m_* frame out, status.
module stft_frame_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int FCW   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [AW:0]      cfg_win,
    input  logic [AW:0]      cfg_hop,
    output logic             cfg_err,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_first,
    output logic             m_last,
    output logic [FCW-1:0]   frm_idx,
    output logic [AW:0]      occupancy,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_e;

    typedef struct packed {
        logic             first;
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_e           state_q, state_d;
    logic [AW:0]      win_q, win_d, hop_q, hop_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      base_q, base_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]   frm_q, frm_d;
    logic             err_q, err_d;
    logic             flush_q, flush_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_q;
    logic             pend_q, pf_q, pl_q, pz_q;
    beat_t            sk_q [2];
    logic [1:0]       sk_cnt_q;

    logic [AW:0] occ, rd_off;
    logic [2:0]  inflight;
    logic        full, wr_en, pop, room, issue, clr;
    logic        cfg_ok;
    beat_t       beat_in;

    assign occ      = wr_ptr_q - base_q;
    assign rd_off   = rd_ptr_q - base_q;
    assign full     = (occ == DEP);
    assign s_ready  = (state_q != IDLE) && !full && !flush_q;
    assign wr_en    = s_valid && s_ready;
    assign pop      = (sk_cnt_q != 2'd0) && m_ready;
    // Reads in flight plus held beats never exceed the two skid slots.
    assign inflight = {1'b0, sk_cnt_q} + {2'b0, pend_q} - {2'b0, pop};
    assign room     = inflight < 3'd2;
    assign cfg_ok   = (cfg_hop != '0) && (cfg_hop <= cfg_win)
                      && (cfg_win <= DEP);

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        hop_d    = hop_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        base_d   = base_q;
        rd_ptr_d = rd_ptr_q;
        frm_d    = frm_q;
        flush_d  = flush_q | (flush && (state_q != IDLE));
        issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    err_d = !cfg_ok;
                    if (cfg_ok) begin
                        win_d   = cfg_win;
                        hop_d   = cfg_hop;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // First read goes out here so data lands one cycle sooner.
                if (occ >= win_q) begin
                    issue   = 1'b1;
                    state_d = STREAM;
                end else if (flush_q) begin
                    state_d = (occ == '0) ? IDLE : FLUSH;
                end
            end
            STREAM, FLUSH: begin
                issue = room && (rd_off != win_q);
                if (pop && sk_q[0].last) begin
                    state_d = (state_q == STREAM) ? FILL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) rd_ptr_d = rd_ptr_q + ONE;
        if (state_q == STREAM && pop && sk_q[0].last) begin
            base_d   = base_q + hop_q;
            rd_ptr_d = base_q + hop_q;
            frm_d    = frm_q + 1'b1;
        end
        clr = (state_q != IDLE) && (state_d == IDLE);
        if (clr) begin
            wr_ptr_d = '0;
            base_d   = '0;
            rd_ptr_d = '0;
            frm_d    = '0;
            flush_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= s_data;
        if (issue) ram_q <= mem[rd_ptr_q[AW-1:0]];
    end

    // Flush frames pad past the real samples with zeros.
    assign beat_in.first = pf_q;
    assign beat_in.last  = pl_q;
    assign beat_in.data  = pz_q ? '0 : ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= DEP;
            hop_q    <= DEP >> 1;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            base_q   <= '0;
            rd_ptr_q <= '0;
            frm_q    <= '0;
            flush_q  <= 1'b0;
            pend_q   <= 1'b0;
            pf_q     <= 1'b0;
            pl_q     <= 1'b0;
            pz_q     <= 1'b0;
            sk_q[0]  <= '0;
            sk_q[1]  <= '0;
            sk_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            hop_q    <= hop_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            rd_ptr_q <= rd_ptr_d;
            frm_q    <= frm_d;
            flush_q  <= flush_d;
            pend_q   <= issue;
            if (issue) begin
                pf_q <= (rd_off == '0);
                pl_q <= (rd_off == win_q - ONE);
                pz_q <= (state_q == FLUSH) && (rd_off >= occ);
            end
            if (pop) sk_q[0] <= sk_q[1];
            if (pend_q) begin
                if (sk_cnt_q == {1'b0, pop}) sk_q[0] <= beat_in;
                else                         sk_q[1] <= beat_in;
            end
            sk_cnt_q <= sk_cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

    assign cfg_err   = err_q;
    assign m_valid   = (sk_cnt_q != 2'd0);
    assign m_data    = sk_q[0].data;
    assign m_first   = sk_q[0].first;
    assign m_last    = sk_q[0].last;
    assign frm_idx   = frm_q;
    assign occupancy = occ;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/stft_frame_buffer.md
Name: stft_frame_buffer

Overview:
- Circular sample buffer that emits overlapping analysis frames (window length WIN, hop HOP) from a continuous sample stream for the STFT/MEL front end.
- It sits between the audio sample source and the windowing/FFT stage.
- Generalises the fixed-parameter circular buffer:
  - runtime-configurable win/hop;
  - valid/ready handshakes on both sides;
  - frame-sequencing FSM with first/last markers and a frame counter;
  - explicit end-of-stream flush with zero padding.

Parameters:
- WIDTH, 32, sample width in bits.
- DEPTH, 512, storage depth in samples; must be a power of 2.
- AW, $clog2(DEPTH), address width. Pointers are AW+1 bits.
- FCW, 16, frame counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  pulse that latches cfg_win/cfg_hop. Accepted only in IDLE.
- cfg_win  in  AW+1  window length WIN.
- cfg_hop  in  AW+1  hop length HOP.
- cfg_err  out  1  sticky flag for an illegal config. Cleared by the next legal cfg_load.
- flush  in  1  end-of-stream pulse.
- s_valid  in  1  input sample valid.
- s_ready  out  1  buffer can accept a sample.
- s_data  in  WIDTH  input sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH  frame sample.
- m_first  out  1  first sample of a frame.
- m_last  out  1  last sample of a frame.
- frm_idx  out  FCW  index of the frame currently being output. Wraps modulo 2^FCW.
- occupancy  out  AW+1  wr_ptr - base_ptr.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: FSM = IDLE and all pointers = 0. All outputs are 0 except s_ready = 0. cfg_err = 0. Internal defaults are WIN = DEPTH, HOP = DEPTH/2.
- Config legality: 1 <= HOP <= WIN <= DEPTH.
  - Illegal config: cfg_err = 1, FSM stays IDLE.
  - Legal config: cfg_err = 0 and the FSM moves to FILL on the next cycle.
  - cfg_load outside IDLE is ignored.
- Pointers:
  - wr_ptr: next write position.
  - base_ptr: first sample of the current frame.
  - rd_ptr: next read address.
  - Memory index is ptr[AW-1:0].
  - Full when wr_ptr - base_ptr == DEPTH. Differences are modulo 2^(AW+1).
- Write side:
  - s_ready = (state != IDLE) && !full && !flushing.
  - A sample is written on s_valid && s_ready; wr_ptr then increments.
  - Write and read may occur in the same cycle.
- Storage: synchronous-read RAM with 1-cycle read latency. The output register stage acts as a 2-entry skid, so m_valid is never dropped while m_ready = 0.
- FSM:
  - IDLE: waits for a legal cfg_load.
  - FILL:
    - Go to STREAM when occupancy >= WIN; set rd_ptr = base_ptr.
    - If flush is pending, go to FLUSH.
  - STREAM:
    - Issues reads rd_ptr .. base_ptr+WIN-1; one read per cycle while the skid has space.
    - After the last sample of the frame is accepted downstream (m_valid && m_ready && m_last): base_ptr += HOP, frm_idx += 1, go to FILL.
    - Overlapping samples stay resident, because base advances only by HOP.
  - FLUSH: entered from FILL when a flush is pending and 0 < occupancy < WIN.
    - Emits one final frame: the occupancy real samples followed by WIN - occupancy zero samples.
    - After the m_last handshake: clear all pointers and frm_idx, go to IDLE.
    - If occupancy == 0 at flush, go directly to IDLE and emit nothing.
- Flush while in STREAM: the current frame completes first, then the normal FILL check is applied. If the remaining samples form a full window, that frame is emitted normally before FLUSH.
- Output markers: m_first is set on output sample 0 of a frame. m_last is set on output sample WIN-1.
- Latency: the first m_valid rises 2 cycles after the write that makes occupancy reach WIN, provided m_ready is high. Steady state is one sample per cycle.
- Backpressure: while m_ready = 0, m_data, m_first and m_last hold stable.
- Memory freeing: freed space is visible to s_ready on the cycle after base_ptr advances.
- Reset mid-frame: everything aborts immediately; no partial frame completes after reset.

Test Plan:
- DEPTH=16, cfg WIN=8 HOP=4, write samples 1..16 with m_ready=1 → frames [1..8], [5..12], [9..16]; frm_idx 0,1,2; m_first and m_last on the correct beats; first m_valid 2 cycles after sample 8 is written.
- cfg WIN=4 HOP=8 → cfg_err=1, busy=0. Then cfg WIN=8 HOP=8 → cfg_err=0, and the bench checks non-overlapping frames [1..8], [9..16].
- DEPTH=16, WIN=16, HOP=4, m_ready=0 → s_ready drops after 16 writes (occupancy=16). With m_ready=1, after the first m_last s_ready returns within 2 cycles and exactly 4 more samples are accepted.
- WIN=8 HOP=4, write 1..10, then flush → frames [1..8], then [5..10,0,0] with m_last on the zero; busy=0 and frm_idx=0 afterwards.
- Random m_ready (50%) with continuous s_valid, 1000 samples → output equals the golden overlapping-frame model, with no dropped or duplicated samples and m_data stable under stall.
- rst_n asserted mid-STREAM → all outputs are 0 in the same cycle. After a new cfg_load and fresh samples, the first frame starts at the new sample 0.
